// File: rtl/board_pkg.sv
// Shared types and constants for the GameBoard row-ROM and the arbiter that
// multiplexes its single read port among the movers.
package board_pkg;

  localparam int ADDR_W   = 5;
  localparam int ROW_W    = 21;
  localparam int NUM_ROWS = 21;
  localparam int REQ_ID_W = 2;

  typedef logic [ROW_W-1:0] row_t;

  // A missing row reads as solid wall so movers never walk off the board.
  localparam row_t WALL_ROW = '1;

  localparam logic [REQ_ID_W-1:0] REQ_PACMAN = 2'd0;
  localparam logic [REQ_ID_W-1:0] REQ_GHOST0 = 2'd1;
  localparam logic [REQ_ID_W-1:0] REQ_GHOST1 = 2'd2;
  localparam logic [REQ_ID_W-1:0] REQ_GHOST2 = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
    logic                oob;
  } rd_tag_t;

  function automatic logic is_oob(input logic [ADDR_W-1:0] row);
    return int'(row) >= NUM_ROWS;
  endfunction

endpackage

// File: rtl/board_rom_arbiter_rr_picker.sv
// Round-robin picker: the first set request at or after ptr (wrapping) wins.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        winner = ID_W'(idx);
        any    = 1'b1;
      end
    end
    if (any) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/board_rom_arbiter.sv
// Shares the GameBoard row-ROM read port among the movers: one round-robin
// grant per cycle, a tag pipeline alongside the ROM, one-hot tagged responses.
module board_rom_arbiter
  import board_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_row,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [ROW_W-1:0]          rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [ROW_W-1:0]          rsp_data,
  output logic                      busy
);

  localparam int DEPTH = ROM_LATENCY + 1;

  logic [REQ_ID_W-1:0] rr_ptr;
  logic [REQ_ID_W-1:0] win_id;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_any;
  logic                grant;
  logic [ADDR_W-1:0]   win_row;
  rd_tag_t             tag_q [DEPTH];
  rd_tag_t             rsp_tag;
  row_t                held_q;

  rr_picker #(.N(NUM_REQ), .ID_W(REQ_ID_W)) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .gnt    (pick_gnt),
    .winner (win_id),
    .any    (pick_any)
  );

  assign grant   = pick_any & reset;
  assign gnt     = grant ? pick_gnt : '0;
  assign win_row = req_row[int'(win_id)*ADDR_W +: ADDR_W];

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      rom_addr <= '0;
    end else if (grant) begin
      rr_ptr   <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + REQ_ID_W'(1);
      rom_addr <= win_row;
    end
  end

  // Tags ride alongside the ROM access; clearing them on reset is what drops
  // any read already in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= grant ? rd_tag_t'{valid: 1'b1, id: win_id, oob: is_oob(win_row)}
                        : '0;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The last tag stage lines up with the ROM's own output register, so the
  // response leaves straight from flops in cycle t+1+ROM_LATENCY.
  assign rsp_tag = tag_q[DEPTH-1];

  always_comb begin
    rsp_valid = '0;
    if (rsp_tag.valid) rsp_valid[rsp_tag.id] = 1'b1;
  end

  assign rsp_data = rsp_tag.valid ? (rsp_tag.oob ? WALL_ROW : rom_data) : held_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             held_q <= '0;
    else if (rsp_tag.valid) held_q <= rsp_data;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | tag_q[i].valid;
  end

endmodule

// File: tb/tb_board_rom_arbiter.sv
// Self-checking bench for board_rom_arbiter: directed vector table, then
// randomized requesters scored against a queue-based reference model.
module tb_board_rom_arbiter;
  import board_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] req_row;
  logic [3:0]  gnt;
  logic [4:0]  rom_addr;
  logic [20:0] rom_data;
  logic [3:0]  rsp_valid;
  logic [20:0] rsp_data;
  logic        busy;

  always #5 clk = ~clk;

  board_rom_arbiter #(.NUM_REQ(NREQ), .ROM_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_row   (req_row),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Synchronous ROM, one edge of latency; rows 21..31 hold non-wall junk.
  logic [20:0] rom [32];
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [3:0]  gnt;
    logic [4:0]  addr;
    logic [3:0]  vld;
    logic [20:0] data;
    logic        busy;
  } obs_t;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [19:0] rows;
    obs_t        exp;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [20:0] data;
  } pend_t;

  pend_t       pq[$];
  vec_t        tv[$];
  int          m_ptr;
  logic [4:0]  m_addr;
  logic [20:0] m_last;
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_obs(input string tag, input obs_t a, input obs_t e);
    check({tag, ".gnt"},       32'(a.gnt),  32'(e.gnt));
    check({tag, ".rom_addr"},  32'(a.addr), 32'(e.addr));
    check({tag, ".rsp_valid"}, 32'(a.vld),  32'(e.vld));
    check({tag, ".rsp_data"},  32'(a.data), 32'(e.data));
    check({tag, ".busy"},      32'(a.busy), 32'(e.busy));
  endtask

  function automatic logic [19:0] rows4(input int r0, input int r1, input int r2, input int r3);
    return {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
  endfunction

  function automatic obs_t mk(input logic [3:0] g, input int a, input logic [3:0] v,
                              input logic [20:0] d, input logic b);
    obs_t o;
    o.gnt = g; o.addr = 5'(a); o.vld = v; o.data = d; o.busy = b;
    return o;
  endfunction

  function automatic logic [20:0] ref_row(input int row);
    return (row >= NUM_ROWS) ? 21'h1FFFFF : rom[row];
  endfunction

  task automatic add(input logic rn, input logic [3:0] r, input logic [19:0] rows, input obs_t e);
    tv.push_back('{rn, r, rows, e});
  endtask

  // One clock cycle: drive inputs after the falling edge, sample at +1, and
  // advance the reference model (pointer search, response queue).
  task automatic step(input logic rn, input logic [3:0] r, input logic [19:0] rows,
                      output obs_t act, output obs_t e);
    int         win;
    logic [4:0] wrow;
    @(negedge clk);
    reset   = rn;
    req     = r;
    req_row = rows;
    if (!rn) begin
      pq.delete();
      m_ptr  = 0;
      m_addr = '0;
      m_last = '0;
    end
    #1;
    act = {gnt, rom_addr, rsp_valid, rsp_data, busy};
    win = -1;
    if (rn) begin
      for (int off = 0; off < NREQ; off++) begin
        int idx;
        idx = (m_ptr + off) % NREQ;
        if (win < 0 && r[idx]) win = idx;
      end
    end
    e.gnt  = '0;
    if (win >= 0) e.gnt[win] = 1'b1;
    e.addr = m_addr;
    e.busy = (pq.size() > 0);
    e.vld  = '0;
    e.data = m_last;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      e.vld[pq[0].id] = 1'b1;
      e.data = pq[0].data;
      m_last = pq[0].data;
      void'(pq.pop_front());
    end
    if (win >= 0) begin
      wrow = rows[win*5 +: 5];
      pq.push_back('{cyc + 1 + LAT, win, ref_row(int'(wrow))});
      m_ptr  = (win + 1) % NREQ;
      m_addr = wrow;
    end
    cyc++;
  endtask

  obs_t        act;
  obs_t        mexp;
  logic [3:0]  rq;
  logic [4:0]  rrow [4];
  int          wait_c [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_ptr    = 0;
    m_addr   = '0;
    m_last   = '0;
    reset    = 1'b0;
    req      = '0;
    req_row  = '0;
    for (int i = 0; i < 32; i++) rom[i] = 21'((i * 32'h1357) ^ 32'h0A0A5);
    rom[5] = 21'h1F0F1;

    // Reset state
    add(0, 4'b0000, 20'h0,            mk(4'b0000, 0, 4'b0000, 21'h0, 0));
    add(0, 4'b0001, rows4(5, 0, 0, 0), mk(4'b0000, 0, 4'b0000, 21'h0, 0));
    // Single request, row 5
    add(1, 4'b0001, rows4(5, 0, 0, 0), mk(4'b0001, 0, 4'b0000, 21'h0, 0));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 5, 4'b0000, 21'h0, 1));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 5, 4'b0001, 21'h1F0F1, 1));
    // Out of range rows 31 and 21
    add(1, 4'b0010, rows4(0, 31, 0, 0), mk(4'b0010, 5, 4'b0000, 21'h1F0F1, 0));
    add(1, 4'b0100, rows4(0, 0, 21, 0), mk(4'b0100, 31, 4'b0000, 21'h1F0F1, 1));
    add(1, 4'b0000, 20'h0,             mk(4'b0000, 21, 4'b0010, 21'h1FFFFF, 1));
    add(1, 4'b0000, 20'h0,             mk(4'b0000, 21, 4'b0100, 21'h1FFFFF, 1));
    add(1, 4'b0000, 20'h0,             mk(4'b0000, 21, 4'b0000, 21'h1FFFFF, 0));
    // Fairness with 0101 held (pointer sits at 3)
    add(1, 4'b0101, rows4(1, 0, 2, 0), mk(4'b0001, 21, 4'b0000, 21'h1FFFFF, 0));
    add(1, 4'b0101, rows4(1, 0, 2, 0), mk(4'b0100, 1, 4'b0000, 21'h1FFFFF, 1));
    add(1, 4'b0101, rows4(1, 0, 2, 0), mk(4'b0001, 2, 4'b0001, rom[1], 1));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 1, 4'b0100, rom[2], 1));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 1, 4'b0001, rom[1], 1));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 1, 4'b0000, rom[1], 0));
    // Reset while a read is in flight
    add(1, 4'b0010, rows4(0, 7, 0, 0), mk(4'b0010, 1, 4'b0000, rom[1], 0));
    add(0, 4'b0000, 20'h0,            mk(4'b0000, 0, 4'b0000, 21'h0, 0));
    add(0, 4'b1111, rows4(3, 4, 5, 6), mk(4'b0000, 0, 4'b0000, 21'h0, 0));
    // All four held from release: rotation restarts at requester 0
    add(1, 4'b1111, rows4(3, 4, 5, 6), mk(4'b0001, 0, 4'b0000, 21'h0, 0));
    add(1, 4'b1111, rows4(3, 4, 5, 6), mk(4'b0010, 3, 4'b0000, 21'h0, 1));
    add(1, 4'b1111, rows4(3, 4, 5, 6), mk(4'b0100, 4, 4'b0001, rom[3], 1));
    add(1, 4'b1111, rows4(3, 4, 5, 6), mk(4'b1000, 5, 4'b0010, rom[4], 1));
    add(1, 4'b1111, rows4(3, 4, 5, 6), mk(4'b0001, 6, 4'b0100, rom[5], 1));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 3, 4'b1000, rom[6], 1));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 3, 4'b0001, rom[3], 1));
    add(1, 4'b0000, 20'h0,            mk(4'b0000, 3, 4'b0000, rom[3], 0));

    for (int k = 0; k < tv.size(); k++) begin
      step(tv[k].rst_n, tv[k].req, tv[k].rows, act, mexp);
      compare_obs($sformatf("vec%0d", k), act, tv[k].exp);
    end

    // Idle for ten cycles: nothing moves
    for (int k = 0; k < 10; k++) begin
      step(1, 4'b0000, 20'h0, act, mexp);
      compare_obs($sformatf("idle%0d", k), act, mk(4'b0000, 3, 4'b0000, rom[3], 0));
    end

    // Randomized requesters that hold req/row until granted
    step(0, 4'b0000, 20'h0, act, mexp);
    compare_obs("rnd_rst", act, mexp);
    rq = '0;
    for (int i = 0; i < 4; i++) begin
      rrow[i]   = '0;
      wait_c[i] = 0;
    end
    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 50) begin
        rq = '0;
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        step(0, rq, 20'h0, act, mexp);
        compare_obs("rnd_midrst", act, mexp);
        step(0, 4'b1111, 20'hFFFFF, act, mexp);
        compare_obs("rnd_midrst", act, mexp);
      end
      for (int i = 0; i < 4; i++)
        if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i]   = 1'b1;
          rrow[i] = 5'($urandom_range(0, 31));
        end
      step(1, rq, {rrow[3], rrow[2], rrow[1], rrow[0]}, act, mexp);
      compare_obs("rnd", act, mexp);
      for (int i = 0; i < 4; i++) begin
        if (mexp.gnt[i]) begin
          check($sformatf("starve%0d", i), 32'(wait_c[i] <= NREQ - 1), 32'd1);
          wait_c[i] = 0;
          rq[i]     = 1'($urandom_range(0, 1));
          rrow[i]   = 5'($urandom_range(0, 31));
        end else if (rq[i]) begin
          wait_c[i]++;
        end
      end
    end

    // Drain so the last responses are scored
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b0000, 20'h0, act, mexp);
      compare_obs("drain", act, mexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_rom_arbiter.md
Name: board_rom_arbiter

Overview:
- Shares the single synchronous GameBoard row-ROM read port among several movers (pacman controller, ghost controllers) that each need wall-row lookups.
- Round-robin grants one row read per cycle, pipelines the ROM access, and returns the row to the requester that issued it, tagged with a one-hot valid.
- Sits between the mover controllers and the one GameBoard instance, so each mover no longer needs its own ROM copies.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is pacman, 1..3 are ghosts.
- ADDR_W, 5, row address width.
- ROW_W, 21, bits per board row; bit x=1 means wall at column x.
- NUM_ROWS, 21, valid rows 0..NUM_ROWS-1.
- ROM_LATENCY, 1, clock edges from the ROM sampling rom_addr to rom_data being valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request; held until granted.
- req_row  in  NUM_REQ*ADDR_W  packed row addresses; slice i belongs to requester i; held with req.
- gnt  out  NUM_REQ  one-hot combinational grant in the accepting cycle.
- rom_addr  out  ADDR_W  registered address to the GameBoard ROM.
- rom_data  in  ROW_W  ROM row output.
- rsp_valid  out  NUM_REQ  one-hot; the row for requester i is on rsp_data this cycle.
- rsp_data  out  ROW_W  returned row.
- busy  out  1  high while any read is in flight in the pipeline.

Behaviour:
- Reset (reset=0, async):
  - rr_ptr=0, rom_addr=0, all pipeline tags invalid.
  - rsp_valid=0, rsp_data=0, busy=0.
  - gnt=0 while reset is low.
- Arbitration, cycle t:
  - Search req starting at rr_ptr and wrap modulo NUM_REQ; the first set bit wins and gets gnt[w]=1.
  - At most one grant per cycle. No grant if req==0.
  - On a grant, rr_ptr <= (w+1) mod NUM_REQ at the end of t. Otherwise rr_ptr holds.
- Handshake:
  - A requester samples gnt in cycle t and may drop or change req and req_row from t+1.
  - A requester with req held high is granted within NUM_REQ cycles. There is no starvation.
- Issue:
  - At the end of t: rom_addr <= req_row[w].
  - Tag stage 0 <= {valid=1, id=w, oob=(req_row[w] >= NUM_ROWS)}.
  - With no grant, rom_addr holds its value and tag stage 0 is invalid.
- Pipeline:
  - The tag shift register is ROM_LATENCY+1 stages deep and advances every cycle. There are no stalls.
- Response:
  - Occurs in cycle t+1+ROM_LATENCY: rsp_valid[id]=1.
  - rsp_data = oob ? all-ones (solid wall) : rom_data.
  - rsp_valid and rsp_data are registered outputs. rsp_data holds its last value when rsp_valid=0.
- Throughput: one response per cycle, back-to-back. Consecutive grants to the same requester are legal and are answered in order.
- Out-of-range rows:
  - Applies to row >= NUM_ROWS, including wrapped 0-1 = 31.
  - The ROM is still addressed; the response is forced to all-ones.
  - No other side effect.
- busy = OR of all tag-stage valid bits.
- Reset mid-operation: in-flight reads are discarded with no rsp_valid and no late response after reset deassertion. Requesters must re-request.
- Simultaneous events: a grant and a response for the same requester may occur in the same cycle. Each port is independent.

Decomposition:
- Package board_pkg:
  - ADDR_W, ROW_W, NUM_ROWS.
  - WALL_ROW constant (all ones).
  - Typedef row_t (logic [ROW_W-1:0]).
  - Typedef rd_tag_t struct {valid, id, oob}.
  - Requester index constants REQ_PACMAN=0 and REQ_GHOST0..2.
- Sub-module rr_picker:
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and encoded winner plus any flag.
  - The arbiter instantiates it once.

Test Plan:
- Single request: req=0001, req_row[0]=5 at t, with ROM row 5 = 0x1F0F1 and ROM_LATENCY=1. Expect gnt=0001 at t, rom_addr=5 from t+1, rsp_valid=0001 and rsp_data=0x1F0F1 at t+2, busy=1 in t+1..t+2.
- All four requesters held high from reset release. Expect grants 0001,0010,0100,1000,0001 on consecutive cycles, and responses in the same order two cycles later.
- Fairness: req=0101 held, rr_ptr=0. Expect gnt alternating 0001,0100,0001.
- Out of range: req_row[1]=31 (wrapped 0-1). Expect rsp_valid=0010 and rsp_data=0x1FFFFF. Also req_row[2]=21 gives the same all-ones.
- Reset mid-flight: grant at t, reset low at t+1 for 2 cycles. Expect rsp_valid=0 throughout and after release, busy=0, and first grant after release from rr_ptr=0.
- Idle: req=0 for 10 cycles. Expect gnt=0, rsp_valid=0, rom_addr unchanged, busy=0.
